// File: rtl/neopixel_frame_ctrl.sv
// rtl/neopixel_frame_ctrl.sv - double-buffered NeoPixel frame store and refresh scheduler
// Optional: NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN adds i_brightness scaling on the o_tx_data read path.
module neopixel_frame_ctrl #(
   parameter int NUM_PIXELS   = 8,
   parameter int FRAME_CYCLES = 450000,
   parameter int CNT_W        = 20
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_wr_en,
   input  logic [7:0]  i_wr_addr,
   input  logic [23:0] i_wr_data,
   input  logic        i_commit,
`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
   input  logic [7:0]  i_brightness,
`endif
   output logic        o_wr_ready,
   output logic        o_commit_pending,
   output logic        o_tx_start,
   input  logic [7:0]  i_tx_addr,
   output logic [23:0] o_tx_data
);
   localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam logic [8:0]       NP       = 9'(NUM_PIXELS);
   localparam logic [7:0]       IDX_LAST = 8'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_COPY  = 3'd4;

   logic [2:0]       state;
   logic             front_sel;
   logic [CNT_W-1:0] frame_cnt;
   logic [7:0]       idx;
   logic [23:0]      mem [2][NUM_PIXELS];
   logic             wr_hit;
   logic [23:0]      raw_px;

   assign o_wr_ready = (state == S_IDLE) || (state == S_WAIT);
   assign o_tx_start = (state == S_START);
   assign wr_hit     = o_wr_ready && i_wr_en && ({1'b0, i_wr_addr} < NP);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state            <= S_CLEAR;
         front_sel        <= 1'b0;
         frame_cnt        <= '0;
         idx              <= '0;
         o_commit_pending <= 1'b0;
      end else begin
         if (o_wr_ready && i_commit)
            o_commit_pending <= 1'b1;
         case (state)
            S_CLEAR: begin
               idx <= idx + 8'd1;
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               frame_cnt <= '0;
               if (i_enable)
                  state <= S_START;
            end
            S_WAIT: begin
               frame_cnt <= frame_cnt + 1'b1;
               if (!i_enable) begin
                  state     <= S_IDLE;
                  frame_cnt <= '0;
               end else if (frame_cnt == CNT_LAST) begin
                  state <= S_START;
               end
            end
            S_START: begin
               // Counter restarts at 1 so the next pulse lands exactly FRAME_CYCLES later.
               frame_cnt <= CNT_W'(1);
               idx       <= '0;
               if (o_commit_pending) begin
                  front_sel        <= ~front_sel;
                  o_commit_pending <= 1'b0;
                  state            <= S_COPY;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_COPY: begin
               frame_cnt <= frame_cnt + 1'b1;
               idx       <= idx + 8'd1;
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= S_WAIT;
               end
            end
            default: begin
               state <= S_CLEAR;
               idx   <= '0;
            end
         endcase
      end
   end

   // Host writes are only possible in IDLE/WAIT, so they never collide with clear or copy.
   always_ff @(posedge i_clk) begin
      if (state == S_CLEAR) begin
         mem[0][idx[AW-1:0]] <= '0;
         mem[1][idx[AW-1:0]] <= '0;
      end else if (state == S_COPY) begin
         mem[~front_sel][idx[AW-1:0]] <= mem[front_sel][idx[AW-1:0]];
      end else if (wr_hit) begin
         mem[~front_sel][i_wr_addr[AW-1:0]] <= i_wr_data;
      end
   end

   assign raw_px = ({1'b0, i_tx_addr} < NP) ? mem[front_sel][i_tx_addr[AW-1:0]] : 24'h0;

`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
   function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] br);
      logic [15:0] prod;
      prod = {8'h0, ch} * ({8'h0, br} + 16'd1);
      return 8'(prod >> 8);
   endfunction

   assign o_tx_data = {scale_ch(raw_px[23:16], i_brightness),
                       scale_ch(raw_px[15:8],  i_brightness),
                       scale_ch(raw_px[7:0],   i_brightness)};
`else
   assign o_tx_data = raw_px;
`endif
endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// tb/tb_neopixel_frame_ctrl.sv - self-checking bench for neopixel_frame_ctrl
// Build with NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN to exercise the brightness path.
module tb_neopixel_frame_ctrl;
   localparam int NP    = 8;
   localparam int FRAME = 100;
   localparam int BRIGHT = 127;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_enable = 1'b0;
   logic        i_wr_en = 1'b0;
   logic [7:0]  i_wr_addr = '0;
   logic [23:0] i_wr_data = '0;
   logic        i_commit = 1'b0;
   logic [7:0]  i_tx_addr = '0;
   logic        o_wr_ready, o_commit_pending, o_tx_start;
   logic [23:0] o_tx_data;
`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
   logic [7:0]  i_brightness = 8'(BRIGHT);
`endif

   neopixel_frame_ctrl #(.NUM_PIXELS(NP), .FRAME_CYCLES(FRAME), .CNT_W(20)) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_enable(i_enable),
      .i_wr_en(i_wr_en),
      .i_wr_addr(i_wr_addr),
      .i_wr_data(i_wr_data),
      .i_commit(i_commit),
`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
      .i_brightness(i_brightness),
`endif
      .o_wr_ready(o_wr_ready),
      .o_commit_pending(o_commit_pending),
      .o_tx_start(o_tx_start),
      .i_tx_addr(i_tx_addr),
      .o_tx_data(o_tx_data)
   );

   always #10 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_start = 0;
   logic [23:0] front_m [NP];
   logic [23:0] back_m [NP];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
      cyc++;
   endtask

   function automatic logic [7:0] scl(input logic [7:0] c);
      int p;
      p = (int'(c) * (BRIGHT + 1)) / 256;
      return 8'(p);
   endfunction

   function automatic logic [23:0] px_exp(input int a);
      logic [23:0] v;
      if (a >= NP) return 24'h0;
      v = front_m[a];
`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
      return {scl(v[23:16]), scl(v[15:8]), scl(v[7:0])};
`else
      return v;
`endif
   endfunction

   task automatic read_px(input int a, output logic [23:0] d);
      i_tx_addr = 8'(a);
      #1;
      d = o_tx_data;
   endtask

   task automatic check_frame(input string tag);
      logic [23:0] d;
      for (int a = 0; a < NP + 2; a++) begin
         read_px(a, d);
         check($sformatf("%s_px%0d", tag, a), 32'(d), 32'(px_exp(a)));
      end
   endtask

   task automatic host_write(input int a, input logic [23:0] d);
      i_wr_en = 1'b1;
      i_wr_addr = 8'(a);
      i_wr_data = d;
      tick();
      i_wr_en = 1'b0;
      if (a < NP) back_m[a] = d;
   endtask

   task automatic host_commit();
      i_commit = 1'b1;
      tick();
      i_commit = 1'b0;
   endtask

   // Swap leaves both banks holding what the host had staged in the back bank.
   task automatic model_swap();
      for (int i = 0; i < NP; i++) front_m[i] = back_m[i];
   endtask

   task automatic wait_start(input string tag, input bit chk_gap);
      int n;
      tick();
      n = 1;
      while (!o_tx_start && n < 4 * FRAME) begin
         tick();
         n++;
      end
      check({tag, "_pulse"}, 32'(o_tx_start), 32'd1);
      if (chk_gap) check({tag, "_gap"}, 32'(cyc - last_start), 32'(FRAME));
      last_start = cyc;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!o_wr_ready && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 32'(o_wr_ready), 32'd1);
   endtask

   initial begin
      int n;
      logic [23:0] d;
      for (int i = 0; i < NP; i++) begin
         front_m[i] = '0;
         back_m[i] = '0;
      end

      // Reset and clear sweep
      repeat (3) tick();
      check("rst_start", 32'(o_tx_start), 32'd0);
      check("rst_pend", 32'(o_commit_pending), 32'd0);
      check("rst_ready", 32'(o_wr_ready), 32'd0);
      i_reset = 1'b0;
      for (int i = 0; i < NP; i++) begin
         check($sformatf("clr_ready_%0d", i), 32'(o_wr_ready), 32'd0);
         tick();
      end
      check("clr_done_ready", 32'(o_wr_ready), 32'd1);
      check_frame("clr");

      n = 0;
      repeat (3 * FRAME) begin
         tick();
         if (o_tx_start) n++;
      end
      check("idle_no_pulse", 32'(n), 32'd0);

      // Enable: immediate first refresh, then FRAME spacing
      i_enable = 1'b1;
      tick();
      check("first_start", 32'(o_tx_start), 32'd1);
      last_start = cyc;
      wait_start("gap0", 1'b1);

      // Commit swap
      tick();
      host_write(3, 24'hFF0000);
      host_commit();
      check("pend_set", 32'(o_commit_pending), 32'd1);
      read_px(3, d);
      check("pre_swap_px3", 32'(d), 32'(px_exp(3)));
      wait_start("swap1", 1'b1);
      check("swap1_pend_at_start", 32'(o_commit_pending), 32'd1);
      read_px(3, d);
      check("swap1_old_px3", 32'(d), 32'(px_exp(3)));
      n = 1;
      tick();
      model_swap();
      check("swap1_pend_clr", 32'(o_commit_pending), 32'd0);
      read_px(3, d);
      check("swap1_new_px3", 32'(d), 32'(px_exp(3)));
      while (!o_wr_ready && n < 40) begin
         n++;
         tick();
      end
      check("swap1_busy_len", 32'(n), 32'(1 + NP));
      check_frame("swap1");

      // Copy-back, with host port hammered while blocked
      host_write(5, 24'h00FF00);
      host_write(9, 24'h123456);
      host_commit();
      wait_start("swap2", 1'b1);
      i_wr_en = 1'b1;
      i_wr_addr = 8'd0;
      i_wr_data = 24'($urandom) | 24'h1;
      i_commit = 1'b1;
      tick();
      model_swap();
      repeat (NP - 1) tick();
      check("blocked_pend", 32'(o_commit_pending), 32'd0);
      i_wr_en = 1'b0;
      i_commit = 1'b0;
      tick();
      check("blocked_pend_after", 32'(o_commit_pending), 32'd0);
      check_frame("swap2");
      wait_ready("swap2");

      // Randomized write/commit rounds
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 4; j++) host_write(int'($urandom_range(0, 9)), 24'($urandom));
         host_commit();
         wait_start($sformatf("rnd%0d", r), 1'b1);
         tick();
         model_swap();
         check_frame($sformatf("rnd%0d", r));
         wait_ready($sformatf("rnd%0d", r));
      end

      // Disable mid-frame with a commit pending, then re-enable
      host_write(1, 24'hFF8040);
      host_write(int'($urandom_range(2, 7)), 24'($urandom));
      host_commit();
      i_enable = 1'b0;
      n = 0;
      repeat (3 * FRAME) begin
         tick();
         if (o_tx_start) n++;
      end
      check("dis_no_pulse", 32'(n), 32'd0);
      check("dis_pend_kept", 32'(o_commit_pending), 32'd1);
      check_frame("dis_old");
      i_enable = 1'b1;
      tick();
      check("reen_start", 32'(o_tx_start), 32'd1);
      tick();
      model_swap();
      check("reen_pend_clr", 32'(o_commit_pending), 32'd0);
      check_frame("reen");
      read_px(1, d);
`ifdef NEOPIXEL_FRAME_CTRL_BRIGHTNESS_EN
      check("bright_px1", 32'(d), 32'h7F4020);
`else
      check("raw_px1", 32'(d), 32'hFF8040);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
